// File: rtl/loader_pkg.sv
// Shared types and constants for the stream-to-SRAM loader.
package loader_pkg;
   localparam int FRAM_ADDR_WIDTH = 10;
   localparam int KRAM_ADDR_WIDTH = 8;

   localparam logic TGT_FRAM = 1'b0;
   localparam logic TGT_KRAM = 1'b1;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FINISH} state_t;
endpackage

// File: rtl/loader_wr_port.sv
// Registered address/data/enable stage for one SRAM write port.
module loader_wr_port #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic [AW-1:0] word_addr,
   input  logic [DW-1:0] data,
   output logic [AW+1:0] addr_byteidx,
   output logic [DW-1:0] wdata,
   output logic          we,
   output logic          en
);
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_byteidx <= '0;
         wdata        <= '0;
         we           <= 1'b0;
         en           <= 1'b0;
      end else begin
         en <= wr;
         we <= wr;
         // Address/data hold between writes so the port looks quiet while idle.
         if (wr) begin
            addr_byteidx <= {word_addr, 2'b00};
            wdata        <= data;
         end
      end
   end
endmodule

// File: rtl/stream_sram_loader.sv
// Loads a word stream into feature or kernel SRAM at a commanded base address.
// Optional macro LOADER_CHECKSUM_EN adds a running-sum output load_checksum.
//
// state  | meaning
// IDLE   | waiting for a load command, cmd_ready high
// LOAD   | accepting beats and writing them to the selected SRAM
// DRAIN  | stream longer than len: swallow beats up to tlast, no writes
// FINISH | one cycle; load_done/load_err registered out next cycle
module stream_sram_loader
   import loader_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int FRAM_BYTE_AW = FRAM_ADDR_WIDTH + 2,
   parameter int KRAM_BYTE_AW = KRAM_ADDR_WIDTH + 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_target,
   input  logic [31:0]             cmd_base,
   input  logic [15:0]             cmd_len,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [FRAM_BYTE_AW-1:0] fram_addr_byteidx,
   output logic [DATA_WIDTH-1:0]   fram_wdata,
   output logic                    fram_we,
   output logic                    fram_en,
   output logic [KRAM_BYTE_AW-1:0] kram_addr_byteidx,
   output logic [DATA_WIDTH-1:0]   kram_wdata,
   output logic                    kram_we,
   output logic                    kram_en,
   input  logic                    accel_running,
   output logic                    busy,
   output logic                    load_done,
   output logic                    load_err
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]   load_checksum
`endif
);
   localparam int FWA = FRAM_BYTE_AW - 2;
   localparam int KWA = KRAM_BYTE_AW - 2;
   localparam int WAW = (FWA > KWA) ? FWA : KWA;

   state_t         state, state_nx;
   logic           tgt_q, err_q;
   logic [15:0]    len_q, cnt_q;
   logic [WAW-1:0] waddr_q;
   logic           cmd_hs, beat, load_beat, last_beat;
   logic           wr_fram, wr_kram;
   logic           unused_base;

   assign unused_base = ^{cmd_base[31:WAW+2], cmd_base[1:0]};

   assign cmd_hs    = cmd_valid && cmd_ready;
   assign beat      = s_axis_tvalid && s_axis_tready;
   assign load_beat = beat && (state == LOAD);
   assign last_beat = ((cnt_q + 16'd1) == len_q);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:   if (cmd_valid) state_nx = (cmd_len == 16'd0) ? FINISH : LOAD;
         LOAD:   if (beat) begin
                    if (last_beat)         state_nx = s_axis_tlast ? FINISH : DRAIN;
                    else if (s_axis_tlast) state_nx = FINISH;
                 end
         DRAIN:  if (beat && s_axis_tlast) state_nx = FINISH;
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Reset overrides the state-derived handshakes so nothing is accepted mid-reset.
   always_comb begin
      cmd_ready     = rst || (state == IDLE);
      s_axis_tready = !rst && (((state == LOAD) && !accel_running) || (state == DRAIN));
      busy          = !rst && (state != IDLE);
      wr_fram       = load_beat && (tgt_q == TGT_FRAM);
      wr_kram       = load_beat && (tgt_q == TGT_KRAM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tgt_q     <= TGT_FRAM;
         len_q     <= '0;
         cnt_q     <= '0;
         waddr_q   <= '0;
         err_q     <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         load_done <= (state == FINISH);
         load_err  <= (state == FINISH) && err_q;
         if (cmd_hs) begin
            tgt_q   <= cmd_target;
            len_q   <= cmd_len;
            cnt_q   <= '0;
            waddr_q <= cmd_base[WAW+1:2];
            err_q   <= 1'b0;
         end else if (load_beat) begin
            cnt_q   <= cnt_q + 16'd1;
            waddr_q <= waddr_q + WAW'(1);
            // Error if tlast and the len-th beat do not coincide.
            if (last_beat != s_axis_tlast) err_q <= 1'b1;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst || cmd_hs)  load_checksum <= '0;
      else if (load_beat) load_checksum <= load_checksum + s_axis_tdata;
   end
`endif

   loader_wr_port #(.AW(FWA), .DW(DATA_WIDTH)) u_fram_port (
      .clk          (clk),
      .rst          (rst),
      .wr           (wr_fram),
      .word_addr    (waddr_q[FWA-1:0]),
      .data         (s_axis_tdata),
      .addr_byteidx (fram_addr_byteidx),
      .wdata        (fram_wdata),
      .we           (fram_we),
      .en           (fram_en)
   );

   loader_wr_port #(.AW(KWA), .DW(DATA_WIDTH)) u_kram_port (
      .clk          (clk),
      .rst          (rst),
      .wr           (wr_kram),
      .word_addr    (waddr_q[KWA-1:0]),
      .data         (s_axis_tdata),
      .addr_byteidx (kram_addr_byteidx),
      .wdata        (kram_wdata),
      .we           (kram_we),
      .en           (kram_en)
   );
endmodule

// File: tb/tb_stream_sram_loader.sv
// Self-checking bench for stream_sram_loader: directed cases plus randomized loads.
module tb_stream_sram_loader;
   import loader_pkg::*;

   localparam int FAW = FRAM_ADDR_WIDTH + 2;
   localparam int KAW = KRAM_ADDR_WIDTH + 2;

   logic clk = 1'b0;
   logic rst;
   logic cmd_valid, cmd_ready, cmd_target;
   logic [31:0] cmd_base;
   logic [15:0] cmd_len;
   logic [31:0] s_axis_tdata;
   logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [FAW-1:0] fram_addr_byteidx;
   logic [31:0] fram_wdata;
   logic fram_we, fram_en;
   logic [KAW-1:0] kram_addr_byteidx;
   logic [31:0] kram_wdata;
   logic kram_we, kram_en;
   logic accel_running, busy, load_done, load_err;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] load_checksum;
`endif

   stream_sram_loader dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
      .cmd_base(cmd_base), .cmd_len(cmd_len),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
      .fram_addr_byteidx(fram_addr_byteidx), .fram_wdata(fram_wdata),
      .fram_we(fram_we), .fram_en(fram_en),
      .kram_addr_byteidx(kram_addr_byteidx), .kram_wdata(kram_wdata),
      .kram_we(kram_we), .kram_en(kram_en),
      .accel_running(accel_running), .busy(busy),
`ifdef LOADER_CHECKSUM_EN
      .load_checksum(load_checksum),
`endif
      .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct {logic tgt; logic [31:0] addr; logic [31:0] data; logic we; int cyc;} wr_t;
   typedef struct {logic err; int cyc;} done_t;

   wr_t   wr_q[$];
   done_t done_q[$];
   logic [31:0] stim[$];
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int hs_cyc, last_acc;
   int gap_max = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fram_en) wr_q.push_back('{TGT_FRAM, 32'(fram_addr_byteidx), fram_wdata, fram_we, cyc});
      if (kram_en) wr_q.push_back('{TGT_KRAM, 32'(kram_addr_byteidx), kram_wdata, kram_we, cyc});
      if (load_done || load_err) done_q.push_back('{load_err, cyc});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s observed timeout expected handshake", tag);
   endtask

   task automatic issue_cmd(input logic tgt, input logic [31:0] base, input logic [15:0] len);
      bit ok = 0;
      wr_q.delete();
      done_q.delete();
      cmd_valid = 1; cmd_target = tgt; cmd_base = base; cmd_len = len;
      for (int k = 0; k < 20 && !ok; k++) begin
         #1;
         if (cmd_ready) begin hs_cyc = cyc; ok = 1; end
         @(negedge clk);
      end
      cmd_valid = 0;
      if (!ok) timeout("cmd_handshake");
   endtask

   task automatic send_beat(input logic [31:0] d, input logic last);
      bit ok = 0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      s_axis_tvalid = 1; s_axis_tdata = d; s_axis_tlast = last;
      for (int k = 0; k < 50 && !ok; k++) begin
         #1;
         if (s_axis_tready) begin last_acc = cyc; ok = 1; end
         @(negedge clk);
      end
      s_axis_tvalid = 0; s_axis_tlast = 0;
      if (!ok) timeout("beat_accept");
   endtask

   // Reference: beats are written until len or tlast, addresses wrap modulo SRAM size.
   task automatic check_result(input logic tgt, input logic [31:0] base, input int len, input int n);
      int nw, words, k;
      logic [31:0] sum, exp_addr;
      nw = (len == 0) ? 0 : ((n < len) ? n : len);
      words = (tgt == TGT_KRAM) ? (1 << KRAM_ADDR_WIDTH) : (1 << FRAM_ADDR_WIDTH);
      k = 0;
      while (done_q.size() == 0 && k < 60) begin @(negedge clk); k++; end
      repeat (2) @(negedge clk);
      chk("done_count", done_q.size(), 1);
      chk("write_count", wr_q.size(), nw);
      sum = 0;
      for (int i = 0; i < nw && i < wr_q.size(); i++) begin
         exp_addr = ((((base >> 2) + i) % words) * 4);
         chk("wr_target", wr_q[i].tgt, tgt);
         chk("wr_addr", wr_q[i].addr, exp_addr);
         chk("wr_data", wr_q[i].data, stim[i]);
         chk("wr_we", wr_q[i].we, 1);
         sum += stim[i];
      end
      if (done_q.size() > 0) begin
         chk("load_err", done_q[0].err, (len != 0) && (n != len));
         if (len == 0) chk("done_latency_len0", done_q[0].cyc, hs_cyc + 2);
         else begin
            chk("done_after_last_beat", done_q[0].cyc, last_acc + 2);
            if (n <= len && wr_q.size() == nw && nw > 0)
               chk("done_after_last_write", done_q[0].cyc, wr_q[nw-1].cyc + 1);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", load_checksum, sum);
`endif
      #1;
      chk("cmd_ready_idle", cmd_ready, 1);
      chk("busy_idle", busy, 0);
      @(negedge clk);
   endtask

   task automatic run_txn(input logic tgt, input logic [31:0] base, input logic [15:0] len);
      int n;
      issue_cmd(tgt, base, len);
      n = (len == 0) ? 0 : stim.size();
      for (int i = 0; i < n; i++) send_beat(stim[i], i == n - 1);
      check_result(tgt, base, len, n);
   endtask

   initial begin
      rst = 1; cmd_valid = 0; cmd_target = 0; cmd_base = 0; cmd_len = 0;
      s_axis_tdata = 0; s_axis_tvalid = 0; s_axis_tlast = 0; accel_running = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_fram_en_we", {fram_en, fram_we}, 0);
      chk("rst_kram_en_we", {kram_en, kram_we}, 0);
      chk("rst_fram_addr_data", {fram_addr_byteidx, fram_wdata}, 0);
      chk("rst_kram_addr_data", {kram_addr_byteidx, kram_wdata}, 0);
      chk("rst_status", {busy, load_done, load_err}, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      // Feature SRAM, exact length
      stim = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      run_txn(TGT_FRAM, 32'h100, 16'd4);
      // Kernel SRAM, stream too short
      stim = '{32'h11, 32'h22};
      run_txn(TGT_KRAM, 32'h20, 16'd3);
      // Stream too long: drained
      stim = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
      run_txn(TGT_FRAM, 32'h40, 16'd2);
      // Zero length
      stim = '{32'h9};
      run_txn(TGT_KRAM, 32'h0, 16'd0);
      // Wrap at top of feature SRAM, upper base bits ignored
      stim = '{32'hDEAD0001, 32'hDEAD0002};
      run_txn(TGT_FRAM, 32'h1000_0FFC, 16'd2);

      // Accelerator stall mid-load
      stim = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
      issue_cmd(TGT_FRAM, 32'h200, 16'd4);
      send_beat(stim[0], 0);
      send_beat(stim[1], 0);
      accel_running = 1; s_axis_tvalid = 1; s_axis_tdata = stim[2];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("stall_tready", s_axis_tready, 0);
         chk("stall_no_write", fram_en, 0);
      end
      @(negedge clk);
      accel_running = 0;
      send_beat(stim[2], 0);
      send_beat(stim[3], 1);
      check_result(TGT_FRAM, 32'h200, 4, 4);

      // Reset during beat 2 of a len=8 load
      issue_cmd(TGT_FRAM, 32'h80, 16'd8);
      send_beat(32'h55, 0);
      #1;
      chk("busy_mid_load", busy, 1);
      @(negedge clk);
      s_axis_tvalid = 1; s_axis_tdata = 32'h66; rst = 1;
      @(negedge clk);
      rst = 0; s_axis_tvalid = 0;
      repeat (6) @(negedge clk);
      chk("rst_abort_no_done", done_q.size(), 0);
      chk("rst_abort_writes", wr_q.size(), 1);
      chk("rst_abort_idle", busy, 0);
      stim = '{32'h7, 32'h8, 32'h9};
      run_txn(TGT_KRAM, 32'h300, 16'd3);

`ifdef LOADER_CHECKSUM_EN
      stim = '{32'd1, 32'd2, 32'd3};
      run_txn(TGT_FRAM, 32'h0, 16'd3);
      chk("checksum_123", load_checksum, 32'd6);
`endif

      // Randomized loads
      gap_max = 2;
      for (int t = 0; t < 16; t++) begin
         logic tgt;
         logic [31:0] base;
         int len, nb, mode;
         tgt = 1'($urandom_range(0, 1));
         base = $urandom;
         len = $urandom_range(0, 6);
         mode = $urandom_range(0, 2);
         if (mode == 1 && len > 1) nb = $urandom_range(1, len - 1);
         else if (mode == 2) nb = len + $urandom_range(1, 3);
         else nb = (len == 0) ? 1 : len;
         stim.delete();
         for (int i = 0; i < nb; i++) stim.push_back($urandom);
         run_txn(tgt, base, 16'(len));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_sram_loader.md
STREAM_SRAM_LOADER -- requirements
Module: stream_sram_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the stream and SRAM word width in bits.
REQ-002 Parameter FRAM_BYTE_AW, default FRAM_ADDR_WIDTH+2, is the feature SRAM byte-address width.
REQ-003 Parameter KRAM_BYTE_AW, default KRAM_ADDR_WIDTH+2, is the kernel SRAM byte-address width.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port cmd_valid/cmd_ready, input/output, 1 bit each: load-command handshake.
REQ-007 Port cmd_target, input, 1 bit: 0 selects feature SRAM, 1 selects kernel SRAM.
REQ-008 Port cmd_base, input, 32 bits: byte start address; bits [1:0] are ignored.
REQ-009 Port cmd_len, input, 16 bits: number of words to load.
REQ-010 Ports s_axis_tdata (DATA_WIDTH), s_axis_tvalid, s_axis_tlast (inputs) and s_axis_tready (output): the word stream.
REQ-011 Ports fram_addr_byteidx (FRAM_BYTE_AW), fram_wdata (DATA_WIDTH), fram_we and fram_en (outputs): feature SRAM BRAM-ctrl write port.
REQ-012 Ports kram_addr_byteidx (KRAM_BYTE_AW), kram_wdata, kram_we and kram_en (outputs): kernel SRAM write port, same form.
REQ-013 Port accel_running, input, 1 bit: accelerator busy; no SRAM write issues while high.
REQ-014 Ports busy, load_done and load_err, outputs, 1 bit each: status; done and err are 1-cycle pulses.

Function
REQ-015 FSM states: IDLE, LOAD, DRAIN, FINISH.
REQ-016 cmd_ready is 1 only in IDLE; a cmd handshake latches target, base[31:2] and len.
  - len != 0: go to LOAD.
  - len == 0: go to FINISH; no writes occur.
REQ-017 s_axis_tready is (state==LOAD && !accel_running) or (state==DRAIN); there is no combinational path from tvalid.
REQ-018 Each accepted LOAD beat produces exactly one write on the next cycle:
  - selected port: en=1, we=1, addr={word_addr,2'b00}, wdata=tdata;
  - other port: en=0, we=0.
REQ-019 Word address increments by 1 per accepted beat and is truncated to the target's address width, so it wraps modulo SRAM size.
REQ-020 The 16-bit beat counter counts accepted beats in LOAD.
REQ-021 Beat number len with tlast=1: go to FINISH, no error.
REQ-022 Beat number len with tlast=0 (stream too long): go to DRAIN; later beats are accepted and discarded, with no writes, up to and including tlast, then go to FINISH with error.
REQ-023 A tlast=1 beat before beat number len (stream too short): that beat is written, then go to FINISH with error.
REQ-024 FINISH lasts one cycle:
  - load_done=1;
  - load_err=1 when the REQ-022 or REQ-023 error path was taken;
  - then go to IDLE.
REQ-025 With a normal-length stream, load_done pulses 1 cycle after the last SRAM write.
REQ-026 busy = (state != IDLE).
REQ-027 accel_running rising mid-LOAD stalls the load: no beat is accepted and all counters hold; the load resumes when it falls.

Reset
REQ-028 While rst=1:
  - state=IDLE, counters=0;
  - outputs: cmd_ready=1, s_axis_tready=0, all en/we=0, addr/wdata=0;
  - busy=0, load_done=0, load_err=0.
REQ-029 Reset mid-LOAD or mid-DRAIN aborts the transfer; no done or err pulse is issued and no write issues on the following cycle.

Configuration
REQ-030 With macro LOADER_CHECKSUM_EN defined:
  - output load_checksum (DATA_WIDTH) is the wrap-around sum of all words written in the current command;
  - it clears on cmd handshake and is valid from the load_done cycle until the next cmd.
REQ-031 Without LOADER_CHECKSUM_EN, the port and its adder are absent.

Structure
REQ-032 Shared package loader_pkg holds:
  - the state enum (IDLE, LOAD, DRAIN, FINISH);
  - the target encoding constants TGT_FRAM=0 and TGT_KRAM=1.
REQ-033 One sub-module, loader_wr_port, holds the registered address/data/enable stage per SRAM; it is instantiated twice, parameterised by address width.

Verification
REQ-034 Feature SRAM load, base=0x100, len=4, beats 0xA0..0xA3 with tlast on the 4th -> fram writes at 0x100,0x104,0x108,0x10C; load_done 1 cycle after the last write; load_err=0.
REQ-035 Kernel SRAM load, len=3, tlast on beat 2 -> 2 kram writes; load_done=1 and load_err=1 in the same cycle.
REQ-036 len=2, 5 beats with tlast on beat 5 -> 2 writes; beats 3-5 are accepted and discarded; load_done=1 and load_err=1 after beat 5.
REQ-037 len=0 command -> no writes; load_done 2 cycles after the cmd handshake; cmd_ready returns high.
REQ-038 Hold accel_running=1 for 10 cycles mid-load -> s_axis_tready=0 and no writes during the hold; data intact after resume. Also base=last word of FRAM, len=2 -> second write at byte address 0.
REQ-039 Assert rst during beat 2 of a len=8 load -> no done or err pulse; next cmd loads correctly. With LOADER_CHECKSUM_EN: len=3 of 1,2,3 -> load_checksum=6.
